gemm_cmd_sequencer: RTL and testbench
=====================================

Name: gemm_cmd_sequencer

Overview:
Master-controller front end for the GEMM engine. Pops 32-bit command words from the command FIFO, parses the header (op/id/len) and payload, and issues each command to the fetch, dispatch or tile engine over a valid/ready handshake. Enforces wait_dispatch/wait_matmul ordering by tracking completion IDs returned by the engines. Sits between the command FIFO (1024 x 32) and the engine command ports.

Parameters:
CMD_W, 32, command word width (header is one word)
ID_W, 8, command id width
PAY_WORDS, 3, payload words for fetch/disp/tile (96-bit payload)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_cmd_word  in  CMD_W  command FIFO data
i_cmd_valid  in  1  FIFO not empty
o_cmd_ready  out  1  pop strobe; a word is consumed when valid & ready
o_fetch_valid / i_fetch_ready  out/in  1  fetch engine handshake
o_disp_valid / i_disp_ready  out/in  1  dispatch engine handshake
o_tile_valid / i_tile_ready  out/in  1  tile engine handshake
o_readout_valid / i_readout_ready  out/in  1  readout request handshake
o_payload  out  PAY_WORDS*CMD_W  payload; word 1 in [31:0], word 3 in [95:64]; shared by all issue ports
o_id  out  ID_W  id of the issued command
i_disp_done  in  1  one-cycle pulse: dispatch command completed
i_disp_done_id  in  ID_W  id of the completed dispatch
i_tile_done  in  1  one-cycle pulse: matmul completed
i_tile_done_id  in  ID_W  id of the completed matmul
o_busy  out  1  high in any state other than HDR
o_err  out  1  sticky: an illegal command was seen
o_err_op  out  8  op of the first illegal command

Behaviour:
- Header word: [7:0] op, [15:8] id, [23:16] len in payload bytes, [31:24] ignored. Payload word count is ceil(len/4).
- Legal commands:
  - F0 fetch, F1 disp, F2 tile: len = 12.
  - F3 wait_disp, F4 wait_tile: len = 4; wait_id = payload[7:0].
  - F5 readout: len = 0.
  - Any other op, or any length mismatch, is illegal.
- Reset (async): state = HDR. All valids, o_busy and o_err = 0. o_payload, o_id, o_err_op = 0. Both done-tracking flags cleared.
- FSM:
  - HDR: o_cmd_ready = 1. On pop, latch op/id/word count and clear the payload register.
    - Illegal: set o_err (sticky). Load o_err_op only if o_err was 0. Go to SKIP if word count > 0, else stay in HDR.
    - Legal with 0 words: go to ISSUE.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: o_cmd_ready = 1. Store word k at bit offset 32k and count pops. After the last pop, go to WAIT if the op is F3/F4, else ISSUE.
  - ISSUE: o_cmd_ready = 0. Exactly one of the four valids is high, selected by op. Payload and id stay stable while valid is high. Return to HDR on the ready cycle.
  - WAIT: o_cmd_ready = 0. Return to HDR in the first cycle the matching tracker is set with last_id == wait_id.
  - SKIP: o_cmd_ready = 1. Drop ceil(len/4) words, then return to HDR.
- Issue timing:
  - First ISSUE cycle is the cycle after the last payload pop. Minimum is header + 3 payload + 1 issue = 5 cycles per command with the engine always ready.
  - No bubble from ready to the next header pop: HDR asserts o_cmd_ready in the cycle after the handshake.
- Completion trackers, one per engine:
  - On a done pulse: last_id <= done_id and seen <= 1, in every state.
  - WAIT compares against the registered tracker and against a done pulse arriving in the same cycle. An equal-id pulse releases WAIT in that cycle.
  - A stale match counts: if the matching id already completed before the wait was parsed, WAIT exits after 1 cycle.
- An empty FIFO (i_cmd_valid = 0) stalls HDR, PAYLOAD and SKIP with no state change.
- No command is reordered. At most one command is outstanding inside the sequencer.

Test Plan:
- Fetch: words {0x000C_01F0, 0x1000_0000, 0x0000_0040, 0x0000_0001}, fetch_ready = 1 -> o_fetch_valid for exactly 1 cycle, 5 cycles after the first pop. o_id = 0x01; o_payload = {0x1, 0x40, 0x1000_0000}.
- Backpressure: tile command issued with i_tile_ready low for 7 cycles -> o_tile_valid stays high 8 cycles with payload/id stable. o_cmd_ready is 0 throughout.
- Wait ordering: wait_disp id 5, then i_disp_done id 4, then id 5 four cycles later -> no release on id 4. Release in the cycle of the id-5 pulse; next header popped the following cycle.
- Stale wait: i_disp_done id 7 before wait_disp id 7 is parsed -> WAIT lasts 1 cycle, then back to HDR.
- Illegal commands: header 0x0008_09AA (op AA, len 8) -> 2 payload words skipped, no valid asserted, o_err = 1, o_err_op = 0xAA. A second bad op 0xBB leaves o_err_op = 0xAA.
- Reset mid-PAYLOAD: assert i_reset after 1 payload word -> all valids and o_busy drop immediately (async). After release, a fresh F5 header gives o_readout_valid 1 cycle later.

Source files
------------

// File: rtl/gemm_cmd_sequencer.sv
// GEMM command sequencer: pops header/payload words from the command FIFO, issues
// each command to its engine, and orders wait_disp/wait_tile against completion ids.
module gemm_cmd_sequencer #(
  parameter int CMD_W     = 32,
  parameter int ID_W      = 8,
  parameter int PAY_WORDS = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [CMD_W-1:0]           i_cmd_word,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  output logic                       o_fetch_valid,
  input  logic                       i_fetch_ready,
  output logic                       o_disp_valid,
  input  logic                       i_disp_ready,
  output logic                       o_tile_valid,
  input  logic                       i_tile_ready,
  output logic                       o_readout_valid,
  input  logic                       i_readout_ready,
  output logic [PAY_WORDS*CMD_W-1:0] o_payload,
  output logic [ID_W-1:0]            o_id,
  input  logic                       i_disp_done,
  input  logic [ID_W-1:0]            i_disp_done_id,
  input  logic                       i_tile_done,
  input  logic [ID_W-1:0]            i_tile_done_id,
  output logic                       o_busy,
  output logic                       o_err,
  output logic [7:0]                 o_err_op
);

  localparam int IDX_W = $clog2(PAY_WORDS + 1);

  localparam logic [2:0] S_HDR     = 3'd0;
  localparam logic [2:0] S_PAYLOAD = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_SKIP    = 3'd4;

  localparam logic [7:0] OP_FETCH   = 8'hF0;
  localparam logic [7:0] OP_DISP    = 8'hF1;
  localparam logic [7:0] OP_TILE    = 8'hF2;
  localparam logic [7:0] OP_WDISP   = 8'hF3;
  localparam logic [7:0] OP_WTILE   = 8'hF4;
  localparam logic [7:0] OP_READOUT = 8'hF5;

  logic [2:0]                 state_q, state_d;
  logic [7:0]                 op_q, op_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic [6:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [PAY_WORDS*CMD_W-1:0] payload_q, payload_d;
  logic                       err_q, err_d;
  logic [7:0]                 err_op_q, err_op_d;
  logic                       disp_seen_q, disp_seen_d;
  logic [ID_W-1:0]            disp_last_q, disp_last_d;
  logic                       tile_seen_q, tile_seen_d;
  logic [ID_W-1:0]            tile_last_q, tile_last_d;

  logic       pop;
  logic [7:0] hdr_op;
  logic [7:0] hdr_len;
  logic [6:0] hdr_words;
  logic       hdr_legal;
  logic       issue_ready;
  logic       is_wait_op;
  logic [ID_W-1:0] wait_id;
  logic       disp_hit;
  logic       tile_hit;
  logic       wait_hit;

  assign hdr_op    = i_cmd_word[7:0];
  assign hdr_len   = i_cmd_word[23:16];
  assign hdr_words = {1'b0, hdr_len[7:2]} + {6'd0, |hdr_len[1:0]};

  always_comb begin
    hdr_legal = 1'b0;
    case (hdr_op)
      OP_FETCH, OP_DISP, OP_TILE: hdr_legal = (hdr_len == 8'd12);
      OP_WDISP, OP_WTILE:         hdr_legal = (hdr_len == 8'd4);
      OP_READOUT:                 hdr_legal = (hdr_len == 8'd0);
      default:                    hdr_legal = 1'b0;
    endcase
  end

  assign o_cmd_ready = (state_q == S_HDR) || (state_q == S_PAYLOAD) || (state_q == S_SKIP);
  assign pop         = i_cmd_valid & o_cmd_ready;

  assign o_fetch_valid   = (state_q == S_ISSUE) && (op_q == OP_FETCH);
  assign o_disp_valid    = (state_q == S_ISSUE) && (op_q == OP_DISP);
  assign o_tile_valid    = (state_q == S_ISSUE) && (op_q == OP_TILE);
  assign o_readout_valid = (state_q == S_ISSUE) && (op_q == OP_READOUT);

  assign issue_ready = (o_fetch_valid & i_fetch_ready) | (o_disp_valid & i_disp_ready) |
                       (o_tile_valid & i_tile_ready) | (o_readout_valid & i_readout_ready);

  // A done pulse in the WAIT cycle itself releases the wait, not just the registered tracker.
  assign is_wait_op = (op_q == OP_WDISP) || (op_q == OP_WTILE);
  assign wait_id    = payload_q[ID_W-1:0];
  assign disp_hit   = (i_disp_done && (i_disp_done_id == wait_id)) ||
                      (disp_seen_q && (disp_last_q == wait_id));
  assign tile_hit   = (i_tile_done && (i_tile_done_id == wait_id)) ||
                      (tile_seen_q && (tile_last_q == wait_id));
  assign wait_hit   = (op_q == OP_WDISP) ? disp_hit : tile_hit;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    err_d     = err_q;
    err_op_d  = err_op_q;
    case (state_q)
      S_HDR: begin
        if (pop) begin
          op_d      = hdr_op;
          id_d      = i_cmd_word[8 +: ID_W];
          cnt_d     = hdr_words;
          idx_d     = '0;
          payload_d = '0;
          if (!hdr_legal) begin
            err_d = 1'b1;
            if (!err_q) err_op_d = hdr_op;
            state_d = (hdr_words != 7'd0) ? S_SKIP : S_HDR;
          end else if (hdr_words == 7'd0) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (pop) begin
          for (int k = 0; k < PAY_WORDS; k++) begin
            if (int'(idx_q) == k) payload_d[k*CMD_W +: CMD_W] = i_cmd_word;
          end
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = is_wait_op ? S_WAIT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ready) state_d = S_HDR;
      end
      S_WAIT: begin
        if (wait_hit) state_d = S_HDR;
      end
      S_SKIP: begin
        if (pop) begin
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_comb begin
    disp_seen_d = disp_seen_q | i_disp_done;
    disp_last_d = i_disp_done ? i_disp_done_id : disp_last_q;
    tile_seen_d = tile_seen_q | i_tile_done;
    tile_last_d = i_tile_done ? i_tile_done_id : tile_last_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_HDR;
      op_q        <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      payload_q   <= '0;
      err_q       <= 1'b0;
      err_op_q    <= '0;
      disp_seen_q <= 1'b0;
      disp_last_q <= '0;
      tile_seen_q <= 1'b0;
      tile_last_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      payload_q   <= payload_d;
      err_q       <= err_d;
      err_op_q    <= err_op_d;
      disp_seen_q <= disp_seen_d;
      disp_last_q <= disp_last_d;
      tile_seen_q <= tile_seen_d;
      tile_last_q <= tile_last_d;
    end
  end

  assign o_payload = payload_q;
  assign o_id      = id_q;
  assign o_busy    = (state_q != S_HDR);
  assign o_err     = err_q;
  assign o_err_op  = err_op_q;

endmodule

// File: tb/tb_gemm_cmd_sequencer.sv
// Directed bench for gemm_cmd_sequencer: hand-computed expectations for issue timing,
// backpressure, wait ordering, illegal-command skipping and asynchronous reset.
module tb_gemm_cmd_sequencer;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_cmd_word;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        o_fetch_valid, i_fetch_ready;
  logic        o_disp_valid, i_disp_ready;
  logic        o_tile_valid, i_tile_ready;
  logic        o_readout_valid, i_readout_ready;
  logic [95:0] o_payload;
  logic [7:0]  o_id;
  logic        i_disp_done;
  logic [7:0]  i_disp_done_id;
  logic        i_tile_done;
  logic [7:0]  i_tile_done_id;
  logic        o_busy;
  logic        o_err;
  logic [7:0]  o_err_op;

  int checks = 0;
  int errors = 0;

  gemm_cmd_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_word(i_cmd_word), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .o_fetch_valid(o_fetch_valid), .i_fetch_ready(i_fetch_ready),
    .o_disp_valid(o_disp_valid), .i_disp_ready(i_disp_ready),
    .o_tile_valid(o_tile_valid), .i_tile_ready(i_tile_ready),
    .o_readout_valid(o_readout_valid), .i_readout_ready(i_readout_ready),
    .o_payload(o_payload), .o_id(o_id),
    .i_disp_done(i_disp_done), .i_disp_done_id(i_disp_done_id),
    .i_tile_done(i_tile_done), .i_tile_done_id(i_tile_done_id),
    .o_busy(o_busy), .o_err(o_err), .o_err_op(o_err_op)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pop(input logic [31:0] w);
    i_cmd_valid = 1'b1;
    i_cmd_word  = w;
    step();
    i_cmd_valid = 1'b0;
  endtask

  function automatic logic any_valid();
    return o_fetch_valid | o_disp_valid | o_tile_valid | o_readout_valid;
  endfunction

  int   hi;
  logic ok;
  logic seen;

  initial begin
    i_reset = 1'b1; i_cmd_word = '0; i_cmd_valid = 1'b0;
    i_fetch_ready = 1'b0; i_disp_ready = 1'b0; i_tile_ready = 1'b0; i_readout_ready = 1'b0;
    i_disp_done = 1'b0; i_disp_done_id = '0; i_tile_done = 1'b0; i_tile_done_id = '0;
    step(); step();
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_err_op", o_err_op, 0);
    chk("rst_valids", any_valid(), 0);
    chk("rst_payload", o_payload, 0);
    chk("rst_id", o_id, 0);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    i_reset = 1'b0;

    // fetch: valid in the 5th cycle counting the header pop as the 1st
    i_fetch_ready = 1'b1;
    pop(32'h000C_01F0);
    chk("fetch_busy", o_busy, 1);
    seen = any_valid();
    pop(32'h1000_0000); seen |= any_valid();
    pop(32'h0000_0040); seen |= any_valid();
    pop(32'h0000_0001);
    chk("fetch_no_early_valid", seen, 0);
    chk("fetch_valid", o_fetch_valid, 1);
    chk("fetch_id", o_id, 8'h01);
    chk("fetch_payload", o_payload, {32'h1, 32'h40, 32'h1000_0000});
    chk("fetch_cmd_ready", o_cmd_ready, 0);
    step();
    chk("fetch_valid_1cyc", o_fetch_valid, 0);
    chk("fetch_back_hdr", o_cmd_ready, 1);

    // tile backpressure
    pop(32'h000C_22F2); pop(32'hAAAA_0001); pop(32'hBBBB_0002); pop(32'hCCCC_0003);
    hi = 0; ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (o_tile_valid) hi++;
      ok &= (o_payload == {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}) && (o_id == 8'h22) && !o_cmd_ready;
      step();
    end
    i_tile_ready = 1'b1;
    if (o_tile_valid) hi++;
    ok &= (o_payload == {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}) && (o_id == 8'h22) && !o_cmd_ready;
    step();
    i_tile_ready = 1'b0;
    chk("tile_valid_cycles", hi, 8);
    chk("tile_stable", ok, 1);
    chk("tile_done_issue", o_tile_valid, 0);

    // wait_disp id 5: id 4 must not release, id 5 releases in its own cycle
    pop(32'h0004_30F3); pop(32'h0000_0005);
    chk("wait_enter", o_busy, 1);
    i_disp_done = 1'b1; i_disp_done_id = 8'd4;
    step();
    i_disp_done = 1'b0;
    ok = o_busy & ~o_cmd_ready;
    step(); ok &= o_busy;
    step(); ok &= o_busy;
    step(); ok &= o_busy;
    chk("wait_hold_id4", ok, 1);
    i_disp_done = 1'b1; i_disp_done_id = 8'd5;
    chk("wait_cmd_ready_low", o_cmd_ready, 0);
    step();
    i_disp_done = 1'b0;
    chk("wait_release", o_busy, 0);
    chk("wait_next_hdr_ready", o_cmd_ready, 1);
    i_readout_ready = 1'b1;
    pop(32'h0000_40F5);
    chk("readout_valid", o_readout_valid, 1);
    chk("readout_id", o_id, 8'h40);
    step();
    chk("readout_1cyc", o_readout_valid, 0);

    // stale completion
    i_disp_done = 1'b1; i_disp_done_id = 8'd7;
    step();
    i_disp_done = 1'b0;
    pop(32'h0004_31F3); pop(32'h0000_0007);
    chk("stale_in_wait", o_busy, 1);
    step();
    chk("stale_exit", o_busy, 0);

    // wait_tile must use the tile tracker, not the disp one holding 7
    pop(32'h0004_32F4); pop(32'h0000_0007);
    step();
    chk("wait_tile_ignores_disp", o_busy, 1);
    i_tile_done = 1'b1; i_tile_done_id = 8'd7;
    step();
    i_tile_done = 1'b0;
    chk("wait_tile_release", o_busy, 0);

    // illegal commands
    pop(32'h0008_09AA);
    chk("ill_skip_busy", o_busy, 1);
    chk("ill_err", o_err, 1);
    chk("ill_err_op", o_err_op, 8'hAA);
    seen = any_valid();
    pop(32'h000C_01F0); seen |= any_valid();
    pop(32'h0000_00F5); seen |= any_valid();
    chk("ill_skip_done", o_busy, 0);
    step(); seen |= any_valid();
    chk("ill_no_valid", seen, 0);
    pop(32'h0000_00BB);
    chk("ill_len0_hdr", o_busy, 0);
    chk("ill_err_op_sticky", o_err_op, 8'hAA);
    pop(32'h0004_00F0);
    chk("ill_len_mismatch_skip", o_busy, 1);
    pop(32'hDEAD_BEEF);
    chk("ill_len_mismatch_done", o_busy, 0);
    chk("ill_err_still", o_err, 1);

    // async reset mid-payload
    pop(32'h000C_01F0); pop(32'h1111_1111);
    chk("rstmid_busy", o_busy, 1);
    #2 i_reset = 1'b1;
    #1;
    chk("rstmid_busy_drop", o_busy, 0);
    chk("rstmid_valids", any_valid(), 0);
    chk("rstmid_err", o_err, 0);
    chk("rstmid_err_op", o_err_op, 0);
    chk("rstmid_payload", o_payload, 0);
    step();
    i_reset = 1'b0;
    pop(32'h0000_50F5);
    chk("post_rst_readout", o_readout_valid, 1);
    chk("post_rst_id", o_id, 8'h50);
    step();
    chk("post_rst_readout_1cyc", o_readout_valid, 0);

    // trackers cleared by reset: wait id 0 must hold until a real id-0 pulse
    pop(32'h0004_60F3); pop(32'h0000_0000);
    step();
    chk("tracker_cleared", o_busy, 1);
    i_disp_done = 1'b1; i_disp_done_id = 8'd0;
    step();
    i_disp_done = 1'b0;
    chk("tracker_id0_release", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
